// File: rtl/banked_ram.sv
// Banked single-port RAM with a full-memory clear sweep.
// Reset and clear both zero every word by walking a pointer across all banks.
module banked_ram_bank #(
    parameter int WIDTH = 16,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

module banked_ram #(
    parameter int WIDTH          = 16,
    parameter int BANK_SEL_BITS  = 3,
    parameter int BANK_ADDR_BITS = 6,
    localparam int ABITS         = BANK_SEL_BITS + BANK_ADDR_BITS,
    localparam int DEPTH         = 2**ABITS,
    localparam int NBANKS        = 2**BANK_SEL_BITS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [ABITS-1:0] address,
    input  logic             clear,
    output logic             busy,
    output logic [WIDTH-1:0] out
);
    typedef enum logic {IDLE, SWEEP} state_t;

    state_t             state_q, state_d;
    logic [ABITS-1:0]   ptr_q, ptr_d;
    logic               busy_q, busy_d;

    logic               we;
    logic [ABITS-1:0]   waddr;
    logic [WIDTH-1:0]   wdata;
    logic [NBANKS-1:0][WIDTH-1:0] rd_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we      = 1'b0;
        waddr   = address;
        wdata   = in;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end else begin
                    we = load;
                end
            end
            SWEEP: begin
                we    = 1'b1;
                waddr = ptr_q;
                wdata = '0;
                // A fresh clear restarts; otherwise stop on the last word without wrapping.
                if (clear) begin
                    ptr_d = '0;
                end else if (ptr_q == {ABITS{1'b1}}) begin
                    state_d = IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: state_d = SWEEP;
        endcase
        busy_d = (state_d == SWEEP);
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        banked_ram_bank #(
            .WIDTH (WIDTH),
            .AW    (BANK_ADDR_BITS)
        ) u_bank (
            .clk   (clk),
            .we    (we && (waddr[ABITS-1 -: BANK_SEL_BITS] == BANK_SEL_BITS'(b))),
            .waddr (waddr[BANK_ADDR_BITS-1:0]),
            .wdata (wdata),
            .raddr (address[BANK_ADDR_BITS-1:0]),
            .rdata (rd_data[b])
        );
    end

    assign busy = busy_q;
    assign out  = busy_q ? '0 : rd_data[address[ABITS-1 -: BANK_SEL_BITS]];
endmodule

// File: doc/banked_ram.md
BANKED_RAM -- requirements
Module: banked_ram

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the data word width in bits.
REQ-002 The module SHALL have parameter BANK_SEL_BITS, default 3, giving the number of bank-select address bits (2**BANK_SEL_BITS banks).
REQ-003 The module SHALL have parameter BANK_ADDR_BITS, default 6, giving the number of word-within-bank address bits.
REQ-004 ABITS = BANK_SEL_BITS + BANK_ADDR_BITS and DEPTH = 2**ABITS (default 512) SHALL be derived, not user-settable.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port in, input, WIDTH bits: write data.
REQ-008 The module SHALL have port load, input, 1 bit: write enable.
REQ-009 The module SHALL have port address, input, ABITS bits: bank = upper BANK_SEL_BITS bits, word = lower BANK_ADDR_BITS bits.
REQ-010 The module SHALL have port clear, input, 1 bit: request to zero the whole memory.
REQ-011 The module SHALL have port busy, output, 1 bit: high while a clear sweep is in progress.
REQ-012 The module SHALL have port out, output, WIDTH bits: read data.

Function
REQ-013 Storage SHALL be 2**BANK_SEL_BITS banks of 2**BANK_ADDR_BITS words each; only the bank chosen by address may see a write enable.
REQ-014 A controller SHALL have two states, IDLE and SWEEP, and an ABITS-bit sweep pointer ptr.
REQ-015 In IDLE with clear=0 and load=1, mem[address] SHALL take in at the rising edge.
REQ-016 In IDLE, out SHALL be mem[address] combinationally, with zero read latency; a same-cycle write SHALL show old data until the edge and new data after it.
REQ-017 In IDLE with clear=1, the next edge SHALL enter SWEEP with ptr=0; load in that cycle SHALL be ignored (clear has priority).
REQ-018 In SWEEP, each edge SHALL write zero to mem[ptr] and increment ptr.
REQ-019 SWEEP SHALL return to IDLE on the edge that writes ptr=DEPTH-1; ptr SHALL never wrap inside a sweep.
REQ-020 clear=1 during SWEEP SHALL restart the sweep (ptr=0) at the next edge.
REQ-021 busy SHALL be a registered signal, high exactly while the state is SWEEP; one uninterrupted sweep SHALL hold busy high for exactly DEPTH cycles.
REQ-022 While busy=1, load SHALL be ignored and out SHALL be forced to zero.
REQ-023 Writes SHALL be full-word only; no partial or byte writes.

Reset
REQ-024 reset_n=0 SHALL asynchronously force state=SWEEP, ptr=0 and busy=1, so out=0 immediately.
REQ-025 Memory contents SHALL NOT be reset directly; after reset_n rises, the sweep SHALL zero every word in DEPTH cycles.
REQ-026 reset_n asserted mid-sweep or mid-write SHALL abort that operation; the sweep SHALL restart from ptr=0 after release.
REQ-027 Reset release SHALL be assumed synchronous to clk by the integrator; no internal synchroniser is required.

Verification (defaults WIDTH=16, DEPTH=512)
REQ-028 Release reset_n, hold clear=load=0 -> busy=1 for exactly 512 edges then 0; reading addresses 0, 0x0C5 and 511 afterwards gives out=0x0000.
REQ-029 After the sweep, load=1, address=0x1C5, in=0xBEEF for one edge -> out=0xBEEF at 0x1C5; out=0x0000 at 0x0C5 (same word, other bank).
REQ-030 Write 0x1234 to 0 and 0xFFFF to 511, then read both -> 0x1234 and 0xFFFF respectively (bank and address boundaries).
REQ-031 In IDLE assert clear=1 and load=1 with address=7, in=0xAAAA for one cycle -> no write; busy=1 from the next edge for 512 cycles; mem[7] reads 0x0000 afterwards.
REQ-032 Assert clear for one cycle at sweep cycle 100 -> busy stays high continuously, for 101+512 cycles in total from reset release.
REQ-033 Assert reset_n=0 between edges mid-sweep, and separately in IDLE after writing 0x5A5A to 3 -> busy=1 and out=0 without waiting for an edge; mem[3] reads 0x0000 after the sweep that follows release.
